// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS-style main control FSM.
// Moore state decode; FETCH strobes are qualified by memory ready.
module multi_cycle_controller #(
  parameter bit IGNORE_READY = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       illegal_op
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       ready;
  logic       legal;

  assign ready = IGNORE_READY ? 1'b1 : mem_ready;
  assign state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    legal = 1'b0;
    unique case (opcode)
      OP_LW, OP_SW, OP_R,
      OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
      default:               legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // rst_n also gates the FETCH write strobes so reset never commits a PC/IR write
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = 3'b000;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready & rst_n;
        pc_write  = ready & rst_n;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~legal;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: instruction-level sequence model
// with randomized opcodes and memory wait states.
module tb_multi_cycle_controller;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] opcode2;
  logic       mem_ready;

  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;
  logic       illegal_op;

  logic       b_pc_write, b_pc_write_cond, b_i_or_d, b_mem_read, b_mem_write;
  logic       b_ir_write, b_mem_to_reg, b_reg_dst, b_reg_write, b_alu_src_a;
  logic [1:0] b_alu_src_b, b_pc_source;
  logic [2:0] b_alu_op;
  logic [3:0] b_state;
  logic       b_illegal_op;

  int tests = 0;
  int fails = 0;
  int seq_st[$];
  bit seq_rdy[$];

  always #5 clk = ~clk;

  multi_cycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .state(state), .illegal_op(illegal_op)
  );

  multi_cycle_controller #(.IGNORE_READY(1'b1)) dut_zw (
    .clk(clk), .rst_n(rst_n), .opcode(opcode2), .mem_ready(1'b0),
    .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond),
    .i_or_d(b_i_or_d), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .ir_write(b_ir_write), .mem_to_reg(b_mem_to_reg), .reg_dst(b_reg_dst),
    .reg_write(b_reg_write), .alu_src_a(b_alu_src_a),
    .alu_src_b(b_alu_src_b), .pc_source(b_pc_source), .alu_op(b_alu_op),
    .state(b_state), .illegal_op(b_illegal_op)
  );

  wire [17:0] act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                     ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                     alu_src_b, pc_source, alu_op, illegal_op};

  function automatic bit is_legal(logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, JMP, ADDI};
  endfunction

  // Control word each state must present, straight from the state table
  function automatic logic [17:0] exp_ctrl(int st, bit rdy, logic [5:0] op);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      0: begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1: begin asb = 2'b11; ill = !is_legal(op); end
      2, 10: begin asa = 1; asb = 2'b10; end
      3: begin mr = 1; iod = 1; end
      4: begin rw = 1; m2r = 1; end
      5: begin mw = 1; iod = 1; end
      6: begin asa = 1; aop = 3'b010; end
      7: begin rw = 1; rd = 1; end
      8: begin asa = 1; aop = 3'b001; pwc = 1; pcs = 2'b01; end
      9: begin pw = 1; pcs = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop, ill};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(int s, bit r);
    seq_st.push_back(s);
    seq_rdy.push_back(r);
  endtask

  // Expected state trace of one instruction with the given wait counts
  task automatic build(logic [5:0] op, int fw, int mw);
    seq_st.delete();
    seq_rdy.delete();
    repeat (fw) push(0, 1'b0);
    push(0, 1'b1);
    push(1, 1'($urandom));
    case (op)
      LW: begin
        push(2, 1'($urandom));
        repeat (mw) push(3, 1'b0);
        push(3, 1'b1);
        push(4, 1'($urandom));
      end
      SW: begin
        push(2, 1'($urandom));
        repeat (mw) push(5, 1'b0);
        push(5, 1'b1);
      end
      RT:   begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
      BEQ:  push(8, 1'($urandom));
      JMP:  push(9, 1'($urandom));
      ADDI: begin push(10, 1'($urandom)); push(11, 1'($urandom)); end
      default: ;
    endcase
  endtask

  // Called at posedge+1; samples at posedge+2, leaves at next posedge+1
  task automatic cyc(bit rdy, logic [5:0] op, int est, int est2);
    mem_ready = rdy;
    opcode = op;
    #1;
    check("state", 32'(state), 32'(est));
    check("ctrl", 32'(act), 32'(exp_ctrl(est, rdy, op)));
    if (est2 >= 0) check("state_zw", 32'(b_state), 32'(est2));
    @(posedge clk);
    #1;
  endtask

  task automatic run(logic [5:0] op);
    foreach (seq_st[i]) cyc(seq_rdy[i], op, seq_st[i], -1);
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{LW, SW, RT, BEQ, JMP, ADDI};
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = 6'b111111;
    opcode2 = RT;

    #3;
    check("rst_state", 32'(state), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_pc_write", 32'(pc_write), 32'd0);
    check("rst_state_zw", 32'(b_state), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // lw zero-wait alongside zero-wait R-type on the ignore-ready instance
    cyc(1'b1, LW, 0, 0);
    cyc(1'b1, LW, 1, 1);
    cyc(1'b1, LW, 2, 6);
    cyc(1'b1, LW, 3, 7);
    cyc(1'b1, LW, 4, 0);

    build(SW, 0, 3);
    run(SW);
    build(BEQ, 0, 0);
    run(BEQ);
    build(6'b111111, 0, 0);
    run(6'b111111);
    build(ADDI, 1, 0);
    run(ADDI);

    for (int n = 0; n < 80; n++) begin
      int k;
      k = $urandom_range(0, 6);
      if (k == 6) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = ops[k];
      end
      build(op, $urandom_range(0, 2), $urandom_range(0, 3));
      run(op);
    end

    // Reset during a MEMRD wait state
    cyc(1'b1, LW, 0, -1);
    cyc(1'b1, LW, 1, -1);
    cyc(1'b1, LW, 2, -1);
    mem_ready = 1'b0;
    #1;
    check("memrd_wait", 32'(state), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_reg_write", 32'(reg_write), 32'd0);
    check("async_rst_pc_write", 32'(pc_write), 32'd0);
    mem_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_state_hold", 32'(state), 32'd0);
      check("rst_no_reg_write", 32'(reg_write), 32'd0);
      check("rst_no_pc_write", 32'(pc_write), 32'd0);
    end
    rst_n = 1'b1;
    build(JMP, 1, 0);
    run(JMP);
    cyc(1'b0, JMP, 0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL have parameter IGNORE_READY, default 0; when 1, mem_ready is treated as constant 1 (zero-wait memory).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1, memory access completes in the cycle this is high.
REQ-006 SHALL have outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write and alu_src_a, each 1 bit, as datapath control strobes.
REQ-007 SHALL have outputs alu_src_b (2 bits: 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2) and pc_source (2 bits: 00 = ALU result, 01 = ALUOut reg, 10 = jump target).
REQ-008 SHALL have output alu_op, 3 bits: 000 = add, 001 = sub, 010 = decode funct field (encoding matches the existing ALU control unit).
REQ-009 SHALL have output state, 4 bits, current FSM state for debug.
REQ-010 SHALL have output illegal_op, 1 bit, a one-cycle pulse on an unsupported opcode.

Function
REQ-011 SHALL implement a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; encodings 12-15 SHALL go to FETCH on the next edge.
REQ-012 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00, and gate ir_write=pc_write=mem_ready; it SHALL stay in FETCH while mem_ready=0 and go to DECODE when it is 1.
REQ-013 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=000; it SHALL branch on opcode: 100011/101011 to MEMADR, 000000 to EXEC, 000100 to BRANCH, 000010 to JUMP, 001000 to ADDIEX, and any other opcode to FETCH with illegal_op=1 for that cycle.
REQ-014 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=000; it SHALL go to MEMRD if opcode=100011, otherwise to MEMWR.
REQ-015 MEMRD SHALL drive mem_read=1, i_or_d=1; it SHALL hold until mem_ready=1 and then go to MEMWB.
REQ-016 MEMWR SHALL drive mem_write=1, i_or_d=1; it SHALL hold until mem_ready=1 and then go to FETCH.
REQ-017 MEMWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=1, then go to FETCH.
REQ-018 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=010, then go to ALUWB; ALUWB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-019 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, then go to FETCH.
REQ-020 JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH.
REQ-021 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=000, then go to ADDIWB; ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0, then go to FETCH.
REQ-022 Every output not listed for a state SHALL be 0 in that state.
REQ-023 Instruction cycle counts with zero-wait memory SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2; each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
REQ-024 mem_read and mem_write SHALL never both be 1, and mem_read/mem_write SHALL stay asserted for every wait cycle of an access.
REQ-025 pc_write and ir_write SHALL never assert except in FETCH (pc_write also in JUMP).

Reset
REQ-026 While rst_n=0 the state SHALL be FETCH immediately, independent of clk, and all strobe outputs except the FETCH-defined ones SHALL be 0; illegal_op SHALL be 0.
REQ-027 Assertion of rst_n mid-instruction, including during a memory wait, SHALL abandon the instruction with no further reg_write, mem_write or pc_write.
REQ-028 The first fetch SHALL start on the first rising clk edge after rst_n deasserts.

Verification
REQ-029 lw (opcode 100011) with mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4 with mem_to_reg=1.
REQ-030 sw with mem_ready=0 for 3 cycles in MEMWR -> mem_write held high for 4 cycles, then state 0; reg_write never 1.
REQ-031 beq -> states 0,1,8; in state 8 alu_op=001, pc_write_cond=1, pc_source=01.
REQ-032 opcode 111111 -> states 0,1,0; illegal_op=1 for exactly one cycle, during state 1.
REQ-033 rst_n pulled low during MEMRD wait -> state=0 before the next clk edge, no reg_write ever asserted; fetch restarts after release.
REQ-034 IGNORE_READY=1 with mem_ready tied to 0 -> R-type completes in 4 cycles: states 0,1,6,7.
